// File: rtl/regfile_param_dump.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and hardwired zero entry, plus a valid/ready dump engine.
module regfile_param_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en_s;
  logic [ADDR_W-1:0] nxt_addr_s;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  // Value a read port would return for addr this cycle, bypass and zero rules included.
  function automatic logic [DATA_W-1:0] eff_val(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (ZERO_REG && (addr == '0)) begin
      return '0;
    end else if (BYPASS && wr_en && (waddr == addr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  assign wr_en_s    = we && !(ZERO_REG && (wa == '0));
  assign nxt_addr_s = addr_q + ADDR_W'(1);

  assign rd1 = eff_val(ra1, mem_q[ra1], wr_en_s, wa, wd);
  assign rd2 = eff_val(ra2, mem_q[ra2], wr_en_s, wa, wd);

  assign dump_busy  = (state_q == RUN);
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_last  = last_q;

  // Storage next-state: single write port.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en_s) begin
      mem_d[wa] = wd;
    end else begin
      mem_d[wa] = mem_q[wa];
    end
  end

  // Dump engine next-state; a stalled beat keeps its captured snapshot.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = RUN;
          addr_d  = '0;
          data_d  = eff_val('0, mem_q[0], wr_en_s, wa, wd);
          valid_d = 1'b1;
          last_d  = (LAST_ADDR == '0);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (valid_q && dump_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            addr_d = nxt_addr_s;
            data_d = eff_val(nxt_addr_s, mem_q[nxt_addr_s], wr_en_s, wa, wd);
            last_d = (nxt_addr_s == LAST_ADDR);
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_regfile_param_dump.sv
// Scoreboard bench: stimulus queues expected reads/beats, a negedge monitor compares.
module tb_regfile_param_dump;

  logic        clk, reset;
  logic [4:0]  ra1, ra2, wa, dump_addr;
  logic [31:0] rd1, rd2, wd, dump_data, nb_rd1, nb_rd2, nb_data;
  logic        we, dump_start, dump_busy, dump_valid, dump_ready, dump_last;
  logic        nb_busy, nb_valid, nb_last;
  logic [4:0]  nb_addr;
  logic        rd_chk;

  int total = 0;
  int bad   = 0;
  int beats = 0;

  typedef struct {logic [31:0] e1, e2, n1, n2; bit chk_nb;} rd_exp_t;
  typedef struct {logic [4:0] a; logic [31:0] d; logic l;} beat_t;
  rd_exp_t rq[$];
  beat_t   dq[$];

  regfile_param_dump #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .dump_start(dump_start), .dump_busy(dump_busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last));

  regfile_param_dump #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .we(we), .wa(wa), .wd(wd), .dump_start(1'b0), .dump_busy(nb_busy),
    .dump_valid(nb_valid), .dump_ready(1'b0), .dump_addr(nb_addr),
    .dump_data(nb_data), .dump_last(nb_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int c = 0; c < 200 && dump_busy; c++) tick;
    chk("dump_idle_timeout", {31'd0, dump_busy}, 32'd0);
  endtask

  function automatic logic [31:0] img(input int i);
    return (i == 0) ? 32'd0 : 32'h100 + i;
  endfunction

  // Monitor: compare reads when flagged and every accepted dump beat.
  always @(negedge clk) begin
    rd_exp_t r;
    beat_t   b;
    if (rd_chk) begin
      if (rq.size() == 0) begin
        chk("rd_queue_empty", 32'd1, 32'd0);
      end else begin
        r = rq.pop_front();
        chk("rd1", rd1, r.e1);
        chk("rd2", rd2, r.e2);
        if (r.chk_nb) begin
          chk("nb_rd1", nb_rd1, r.n1);
          chk("nb_rd2", nb_rd2, r.n2);
        end
      end
    end
    if (dump_valid && dump_ready) begin
      beats++;
      if (dq.size() == 0) begin
        chk("unexpected_beat", {27'd0, dump_addr}, 32'hFFFF_FFFF);
      end else begin
        b = dq.pop_front();
        chk("beat_addr", {27'd0, dump_addr}, {27'd0, b.a});
        chk("beat_data", dump_data, b.d);
        chk("beat_last", {31'd0, dump_last}, {31'd0, b.l});
      end
    end
  end

  initial begin
    int b0;
    reset = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'd0; ra1 = 5'd0; ra2 = 5'd0;
    dump_start = 1'b0; dump_ready = 1'b0; rd_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_busy", {31'd0, dump_busy}, 32'd0);
    chk("rst_last", {31'd0, dump_last}, 32'd0);
    chk("rst_addr", {27'd0, dump_addr}, 32'd0);
    chk("rst_data", dump_data, 32'd0);
    reset = 1'b1;
    tick;

    rd_chk = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      rq.push_back('{32'd0, 32'd0, 32'd0, 32'd0, 1'b1});
      tick;
    end
    // Entry 0: zero-wired on main instance, ordinary on the other.
    we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra1 = 5'd0; ra2 = 5'd0;
    rq.push_back('{32'd0, 32'd0, 32'd0, 32'd0, 1'b1});
    tick;
    we = 1'b0;
    rq.push_back('{32'd0, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1});
    tick;
    // Same-cycle write/read of entry 5.
    we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra1 = 5'd5; ra2 = 5'd5;
    rq.push_back('{32'h12345678, 32'h12345678, 32'd0, 32'd0, 1'b1});
    tick;
    we = 1'b0;
    rq.push_back('{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b1});
    tick;
    rd_chk = 1'b0;

    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'h100 + i;
      tick;
    end
    we = 1'b0;

    // Dump 1: ready held high.
    for (int i = 0; i < 32; i++) dq.push_back('{5'(i), img(i), (i == 31)});
    dump_ready = 1'b1; dump_start = 1'b1; b0 = beats;
    tick;
    dump_start = 1'b0;
    chk("d1_first_valid", {31'd0, dump_valid}, 32'd1);
    chk("d1_first_addr", {27'd0, dump_addr}, 32'd0);
    repeat (31) tick;
    chk("d1_busy_at_last", {31'd0, dump_busy}, 32'd1);
    chk("d1_last_flag", {31'd0, dump_last}, 32'd1);
    tick;
    chk("d1_busy_after", {31'd0, dump_busy}, 32'd0);
    chk("d1_valid_after", {31'd0, dump_valid}, 32'd0);
    chk("d1_beats", beats - b0, 32'd32);
    chk("d1_queue_left", dq.size(), 32'd0);

    // Dump 2: stall at beat 7 with writes, bypass into beat 9, ignored restart.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = (i == 8) ? 32'hBBBB : (i == 9) ? 32'hCCCC : img(i);
      dq.push_back('{5'(i), v, (i == 31)});
    end
    dump_start = 1'b1; b0 = beats;
    tick;
    dump_start = 1'b0;
    repeat (7) tick;
    dump_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      we = (k < 2); wa = (k == 0) ? 5'd7 : 5'd8; wd = (k == 0) ? 32'hAAAA : 32'hBBBB;
      tick;
      chk("stall_addr", {27'd0, dump_addr}, 32'd7);
      chk("stall_data", dump_data, 32'h107);
    end
    we = 1'b0; dump_ready = 1'b1;
    tick;
    we = 1'b1; wa = 5'd9; wd = 32'hCCCC; dump_start = 1'b1;
    tick;
    we = 1'b0; dump_start = 1'b0;
    wait_idle;
    chk("d2_beats", beats - b0, 32'd32);
    chk("d2_queue_left", dq.size(), 32'd0);

    // Dump 3: reset asserted while beat 12 is presented.
    for (int i = 0; i < 12; i++) begin
      logic [31:0] v;
      v = (i == 7) ? 32'hAAAA : (i == 8) ? 32'hBBBB : (i == 9) ? 32'hCCCC : img(i);
      dq.push_back('{5'(i), v, 1'b0});
    end
    dump_start = 1'b1; b0 = beats;
    tick;
    dump_start = 1'b0;
    repeat (12) tick;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, dump_busy}, 32'd0);
    chk("mid_rst_last", {31'd0, dump_last}, 32'd0);
    chk("mid_rst_beats", beats - b0, 32'd12);
    chk("mid_rst_queue_left", dq.size(), 32'd0);
    rd_chk = 1'b1;
    ra1 = 5'd7; ra2 = 5'd9;
    rq.push_back('{32'd0, 32'd0, 32'd0, 32'd0, 1'b1});
    tick;
    ra1 = 5'd8; ra2 = 5'd31;
    rq.push_back('{32'd0, 32'd0, 32'd0, 32'd0, 1'b1});
    tick;
    rd_chk = 1'b0;
    reset = 1'b1;
    tick;

    for (int i = 0; i < 32; i++) dq.push_back('{5'(i), 32'd0, (i == 31)});
    dump_start = 1'b1; b0 = beats;
    tick;
    dump_start = 1'b0;
    wait_idle;
    chk("d4_beats", beats - b0, 32'd32);
    chk("d4_queue_left", dq.size(), 32'd0);
    chk("rd_queue_left", rq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param_dump.md
Name: regfile_param_dump

Overview:
- Parametrised successor to the MIPS datapath register file: 2 asynchronous read ports, 1 synchronous write port.
- Adds optional write-to-read bypass, optional hardwired-zero register 0, and a true reset clear.
- Replaces the flat all-registers debug bus with a serial dump engine: a valid/ready stream that emits every entry once per request.
- Sits between decode (read addresses) and writeback (write port); the dump stream feeds the debug/UART path.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns the write data; 0 = returns stored contents.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra1  in  ADDR_W  read address, port 1 (rs).
- ra2  in  ADDR_W  read address, port 2 (rt).
- rd1  out  DATA_W  read data, port 1.
- rd2  out  DATA_W  read data, port 2.
- we  in  1  write enable.
- wa  in  ADDR_W  write address (rd).
- wd  in  DATA_W  write data.
- dump_start  in  1  request a full dump; sampled only in IDLE.
- dump_busy  out  1  high while in RUN.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  sink accepts the beat.
- dump_addr  out  ADDR_W  index of the current beat.
- dump_data  out  DATA_W  contents of entry dump_addr.
- dump_last  out  1  high on the beat with dump_addr = DEPTH-1.

Behaviour:
- Reset (reset=0, asynchronous): all entries cleared to 0. FSM goes to IDLE. dump_valid, dump_busy and dump_last = 0. dump_addr and dump_data = 0. Reads return 0.
- Write: on rising clk edge, if we=1, entry[wa] <= wd. This is suppressed when ZERO_REG=1 and wa=0.
- Read: combinational, zero latency. rdN = entry[raN].
  - ZERO_REG=1 and raN=0: rdN = 0 regardless of bypass.
  - BYPASS=1 and we=1 and wa=raN (not zero-suppressed): rdN = wd in the same cycle.
  - Both ports may read the same address.
- "Effective value" of address X in a cycle = exactly what a read port would return for X in that cycle (bypass and zero rules included).
- Dump FSM has states IDLE and RUN.
  - IDLE + dump_start=1: next state RUN; dump_addr <= 0; dump_data <= effective value of entry 0 this cycle; dump_valid <= 1. This is 1-cycle latency from start to first beat.
  - IDLE + dump_start=0: stay in IDLE.
  - RUN with dump_valid=1 and dump_ready=0: dump_addr, dump_data and dump_last hold stable, even if that entry is written meanwhile. The beat is a snapshot taken at capture.
  - RUN with handshake (valid&ready) and dump_addr<DEPTH-1: dump_addr <= dump_addr+1; dump_data <= effective value of the next address in that cycle, so a same-cycle write to it is included. Back-to-back beats with ready held high give 1 beat per cycle.
  - RUN with handshake and dump_addr=DEPTH-1 (dump_last=1): next state IDLE; dump_valid <= 0; dump_last <= 0. No wrap. dump_start in the same cycle is ignored; a new dump needs start sampled in IDLE.
  - dump_start while in RUN is ignored; requests are not queued.
- dump_last = dump_valid & (dump_addr = DEPTH-1). dump_busy = (state = RUN).
- dump_ready while dump_valid=0 has no effect.
- Total dump = DEPTH beats. With ready held high, start-to-return-to-IDLE = DEPTH+1 cycles.
- The dump never blocks or delays the read or write ports.
- Reset asserted mid-dump: immediate return to IDLE, outputs cleared, no further beats.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all 0. Write 0xDEADBEEF to entry 0 with ZERO_REG=1 -> rd1 at ra1=0 stays 0.
- Write 0x12345678 to entry 5; in the same cycle ra1=5, ra2=5 -> rd1=rd2=0x12345678 with BYPASS=1. Repeat with BYPASS=0 -> both read 0 that cycle and 0x12345678 the next cycle.
- Load entry i = 0x100+i for i=1..31, pulse dump_start, ready held high -> 32 beats on consecutive cycles: (0,0), (1,0x101) … (31,0x11F). dump_last only on addr 31; dump_busy falls the cycle after.
- Mid-dump, drop ready at addr 7 for 4 cycles while writing 0xAAAA to entry 7 and 0xBBBB to entry 8 -> beat 7 holds the old value 0x107; beat 8 shows 0xBBBB.
- Write entry 9 = 0xCCCC in the same cycle as the handshake of beat 8 -> beat 9 = 0xCCCC. Pulse dump_start during RUN -> no restart; exactly 32 beats total.
- Assert reset at beat 12 of a dump -> dump_valid=0 and dump_busy=0 immediately, all entries read 0; a new dump_start yields a fresh 32-beat all-zero dump.
